pipelined_cla_add_sub: RTL
==========================

// Module: pipelined_cla_add_sub
// PURPOSE
//  Parametrised, pipelined carry-lookahead adder/subtractor.
//  Successor to the 4-bit combinational CLA add/sub in this datapath.
//  Splits a WIDTH-bit operation into GROUP-bit CLA slices, with one register stage per slice.
//  Carries ripple slice-to-slice through those registers, giving one result per clock at full throughput.
//  Adds a valid/ready handshake and signed overflow and zero flags.
// PARAMETERS
//  WIDTH  16  operand/result width; must be a multiple of GROUP
//  GROUP  4   bits per CLA slice (generate/propagate lookahead inside a slice)
//  NS = WIDTH/GROUP (derived localparam): number of pipeline stages = latency
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      synchronous, active-high reset
//  in_valid   in   1      A/B/Cin/control valid this cycle
//  in_ready   out  1      block accepts input this cycle
//  A          in   WIDTH  operand A
//  B          in   WIDTH  operand B
//  Cin        in   1      carry-in to bit 0
//  control    in   1      0: A+B+Cin; 1: A+~B+Cin (Cin=1 gives A-B)
//  out_valid  out  1      result valid
//  out_ready  in   1      downstream accepts result
//  sum        out  WIDTH  result
//  Cout       out  1      carry out of MSB
//  overflow   out  1      signed overflow: carry into MSB XOR carry out of MSB
//  zero       out  1      sum == 0
// BEHAVIOUR
//  - One clock; reset is synchronous and active-high.
//    Reset clears all stage valids, out_valid, sum, Cout, overflow and zero to 0.
//  - adv = ~out_valid | out_ready.
//    in_ready = adv (combinational from out_ready).
//    All stages shift together when adv=1 and hold otherwise (global stall).
//  - Input transfer: in_valid & in_ready. A bubble enters stage 0 when in_valid=0 and adv=1.
//  - Stage k (0..NS-1) computes slice k [k*GROUP +: GROUP] with GROUP-bit CLA logic.
//    Stage k's carry-in is Cin for k=0, otherwise the registered carry out of stage k-1.
//  - Skew registers: carry each op's upper slices forward, and deskew the lower result slices.
//    B is inverted per slice using the op's registered control bit.
//  - Latency: exactly NS cycles from accepted input to out_valid (no stall).
//    Throughput: 1 op/clk while out_ready=1.
//  - Holding: out_valid=1 & out_ready=0 freezes sum, Cout, overflow, zero and every stage.
//    No input is lost and no result is duplicated.
//  - Transfers in order. Stall on a bubble still stalls the whole pipe (no bubble collapse).
//  - Arithmetic is modulo 2^WIDTH; Cout is the true carry.
//    For subtract, Cout=1 means no borrow (A>=B unsigned when Cin=1).
//  - overflow and zero are computed from final-stage values.
//    They are registered with sum and valid only when out_valid=1 (0 after reset).
//  - Reset mid-operation: all in-flight ops are discarded; the first output after reset is from a new input.
//  - Simultaneous final-stage output and new input with adv=1: both transfer in the same cycle.
// CONFIGURATION
//  SATURATE_EN defined:
//    - Adds an input sat_en (1 bit), captured with the op.
//    - When sat_en=1 and overflow=1, sum is clamped to 0x7F..F (positive overflow) or 0x80..0 (negative overflow).
//    - Overflow sign is taken from MSB of A and of the effective B.
//    - overflow still reports 1; Cout is unchanged; zero reflects the clamped sum.
//    - Clamping is performed in the final stage; latency is unchanged.
//  SATURATE_EN undefined:
//    - No sat_en port; sum always wraps.
// TESTING (WIDTH=16, GROUP=4, NS=4 unless noted)
//  1. rst=1 two cycles -> out_valid=0, sum=0, Cout=0, overflow=0, zero=0, in_ready=1.
//  2. A=3,B=5,Cin=0,control=0 -> after 4 clk: sum=0x0008, Cout=0, ovf=0, zero=0.
//     Also: A=0xFFFF,B=1,Cin=1,control=0 -> sum=0x0001, Cout=1, ovf=0.
//  3. Subtract with control=1,Cin=1:
//     A=6,B=12 -> sum=0xFFFA, Cout=0, ovf=0.
//     A=12,B=6 -> sum=0x0006, Cout=1.
//     A=B=0x1234 -> sum=0, zero=1, Cout=1.
//  4. A=0x7FFF,B=1,add -> sum=0x8000, ovf=1.
//     With SATURATE_EN and sat_en=1 -> sum=0x7FFF, ovf=1.
//     With SATURATE_EN, A=0x8000,B=1,sub (Cin=1) -> sum=0x8000 clamp (no ovf? ovf=1, sum=0x8000).
//  5. Stream 20 random ops back-to-back with out_ready toggled pseudo-randomly.
//     Required: results emerge in order, match a reference model, with none dropped or duplicated,
//     and outputs stay stable while stalled.
//  6. rst asserted with 3 ops in flight -> next cycle out_valid=0.
//     A fresh op after reset is the first result, 4 clk after acceptance.

Source files
------------

// File: rtl/pipelined_cla_add_sub_if.sv
// Valid/ready bus for pipelined_cla_add_sub.
// With SATURATE_EN defined the bus also carries sat_en alongside the operands.
interface pipelined_cla_add_sub_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             control;
`ifdef SATURATE_EN
    logic             sat_en;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] sum;
    logic             Cout;
    logic             overflow;
    logic             zero;

`ifdef SATURATE_EN
    modport master (
        output in_valid, A, B, Cin, control, sat_en, out_ready,
        input  in_ready, out_valid, sum, Cout, overflow, zero
    );
    modport slave (
        input  in_valid, A, B, Cin, control, sat_en, out_ready,
        output in_ready, out_valid, sum, Cout, overflow, zero
    );
`else
    modport master (
        output in_valid, A, B, Cin, control, out_ready,
        input  in_ready, out_valid, sum, Cout, overflow, zero
    );
    modport slave (
        input  in_valid, A, B, Cin, control, out_ready,
        output in_ready, out_valid, sum, Cout, overflow, zero
    );
`endif
endinterface

// File: rtl/pipelined_cla_add_sub.sv
// Pipelined carry-lookahead adder/subtractor: one GROUP-bit CLA slice per stage, global stall.
// Optional SATURATE_EN macro adds sat_en and clamps signed overflow in the final stage.
module pipelined_cla_add_sub #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned GROUP = 4
) (
    input logic                    clk,
    input logic                    rst,
    pipelined_cla_add_sub_if.slave bus
);
    localparam int unsigned NS = WIDTH / GROUP;
    // Skew stages sitting in front of the output stage; WIDTH must be at least 2*GROUP.
    localparam int unsigned NK = NS - 1;

    typedef logic [WIDTH-1:0] word_t;

    function automatic logic [GROUP:0] cla_carries(input logic [GROUP-1:0] g,
                                                   input logic [GROUP-1:0] p,
                                                   input logic             ci);
        logic [GROUP:0] c;
        logic           pp;
        c[0] = ci;
        for (int i = 0; i < GROUP; i++) begin
            pp       = p[i];
            c[i + 1] = g[i];
            for (int j = i - 1; j >= 0; j--) begin
                c[i + 1] = c[i + 1] | (pp & g[j]);
                pp       = pp & p[j];
            end
            c[i + 1] = c[i + 1] | (pp & ci);
        end
        return c;
    endfunction

    logic  vld_q [NK], vld_d [NK];
    word_t a_q   [NK], a_d   [NK];
    word_t b_q   [NK], b_d   [NK];
    word_t res_q [NK], res_d [NK];
    logic  ctl_q [NK], ctl_d [NK];
    logic  cy_q  [NK], cy_d  [NK];
`ifdef SATURATE_EN
    logic  sat_q [NK], sat_d [NK];
    logic  st_sat [NS];
`endif

    logic  out_valid_q, out_valid_d;
    word_t sum_q, sum_d;
    logic  cout_q, cout_d, ovf_q, ovf_d, zero_q, zero_d;

    logic  st_vld [NS], st_ctl [NS], st_cy [NS];
    word_t st_a [NS], st_b [NS], st_res [NS];
    word_t nx_res [NS];
    logic  nx_cy [NS];
    logic  msb_cin;
    logic  adv;

    assign adv          = ~out_valid_q | bus.out_ready;
    assign bus.in_ready = adv;

    always_comb begin : stage_logic
        logic [GROUP-1:0] as, bs;
        logic [GROUP:0]   c;
        st_vld[0] = bus.in_valid;
        st_a[0]   = bus.A;
        st_b[0]   = bus.B;
        st_ctl[0] = bus.control;
        st_cy[0]  = bus.Cin;
        st_res[0] = '0;
`ifdef SATURATE_EN
        st_sat[0] = bus.sat_en;
`endif
        for (int k = 1; k < NS; k++) begin
            st_vld[k] = vld_q[k - 1];
            st_a[k]   = a_q[k - 1];
            st_b[k]   = b_q[k - 1];
            st_ctl[k] = ctl_q[k - 1];
            st_cy[k]  = cy_q[k - 1];
            st_res[k] = res_q[k - 1];
`ifdef SATURATE_EN
            st_sat[k] = sat_q[k - 1];
`endif
        end
        msb_cin = 1'b0;
        for (int k = 0; k < NS; k++) begin
            as        = st_a[k][k*GROUP +: GROUP];
            bs        = st_b[k][k*GROUP +: GROUP] ^ {GROUP{st_ctl[k]}};
            c         = cla_carries(as & bs, as ^ bs, st_cy[k]);
            nx_res[k] = st_res[k];
            nx_res[k][k*GROUP +: GROUP] = (as ^ bs) ^ c[GROUP-1:0];
            nx_cy[k]  = c[GROUP];
            if (k == NS - 1) msb_cin = c[GROUP-1];
        end
    end

    always_comb begin : next_state
        word_t fsum;
        logic  fovf;
        fsum = nx_res[NS-1];
        fovf = msb_cin ^ nx_cy[NS-1];
`ifdef SATURATE_EN
        // Overflow implies A and effective B share a sign; A's MSB picks the clamp direction.
        if (st_sat[NS-1] && fovf) begin
            fsum = st_a[NS-1][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
        out_valid_d = out_valid_q;
        sum_d       = sum_q;
        cout_d      = cout_q;
        ovf_d       = ovf_q;
        zero_d      = zero_q;
        if (adv) begin
            out_valid_d = st_vld[NS-1];
            sum_d       = fsum;
            cout_d      = nx_cy[NS-1];
            ovf_d       = st_vld[NS-1] & fovf;
            zero_d      = st_vld[NS-1] & (fsum == '0);
        end
        for (int k = 0; k < NK; k++) begin
            vld_d[k] = adv ? st_vld[k] : vld_q[k];
            a_d[k]   = adv ? st_a[k]   : a_q[k];
            b_d[k]   = adv ? st_b[k]   : b_q[k];
            ctl_d[k] = adv ? st_ctl[k] : ctl_q[k];
            cy_d[k]  = adv ? nx_cy[k]  : cy_q[k];
            res_d[k] = adv ? nx_res[k] : res_q[k];
`ifdef SATURATE_EN
            sat_d[k] = adv ? st_sat[k] : sat_q[k];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < NK; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                ctl_q[k] <= 1'b0;
                cy_q[k]  <= 1'b0;
                res_q[k] <= '0;
`ifdef SATURATE_EN
                sat_q[k] <= 1'b0;
`endif
            end
            out_valid_q <= 1'b0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            ovf_q       <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            vld_q       <= vld_d;
            a_q         <= a_d;
            b_q         <= b_d;
            ctl_q       <= ctl_d;
            cy_q        <= cy_d;
            res_q       <= res_d;
`ifdef SATURATE_EN
            sat_q       <= sat_d;
`endif
            out_valid_q <= out_valid_d;
            sum_q       <= sum_d;
            cout_q      <= cout_d;
            ovf_q       <= ovf_d;
            zero_q      <= zero_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_q;
    assign bus.Cout      = cout_q;
    assign bus.overflow  = ovf_q;
    assign bus.zero      = zero_q;
endmodule
